// File: rtl/ev_motor_pkg.sv
// ev_motor_pkg: shared channel state encoding, default widths and target computation.
package ev_motor_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, HOLD, DERATE} ch_state_e;
  localparam int DEF_DW = 8;
  localparam int DEF_IW = 4;
  localparam int DEF_TW = 7;
  function automatic int unsigned target_calc(input int unsigned accel, input int unsigned brake,
                                              input int unsigned sh);
    return (accel > brake) ? (accel - brake) << sh : 0;
  endfunction
endpackage

// File: rtl/ev_motor_channel.sv
// ev_motor_channel: one drive channel - target, derate hysteresis, slew ramp, state, duty and PWM.
module ev_motor_channel
  import ev_motor_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int IW     = DEF_IW,
  parameter int TW     = DEF_TW,
  parameter int STEP   = 4,
  parameter int T_HOT  = 85,
  parameter int T_COOL = 75
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  input  logic          wrap,
  input  logic [DW-1:0] cnt,
  input  logic          cmd_we,
  input  logic          cmd_stop,
  input  logic [IW-1:0] accel,
  input  logic [IW-1:0] brake,
  input  logic [TW-1:0] temp,
  output logic          pwm,
  output logic [DW-1:0] speed,
  output logic          overheat,
  output logic          busy
);
  localparam logic [DW-1:0] STEP_W = DW'(STEP);
  logic [DW-1:0] tgt_q, tgt_d, spd_q, spd_d, duty_q, duty_d, eff, eff_d, diff, mv;
  logic oh_q, oh_d, pwm_q, pwm_d;
  ch_state_e st_q, st_d;
  always_comb begin
    tgt_d  = cmd_stop ? '0 : cmd_we ? DW'(target_calc(32'(accel), 32'(brake), 32'(DW - IW))) : tgt_q;
    oh_d   = (temp >= TW'(T_HOT)) ? 1'b1 : (temp <= TW'(T_COOL)) ? 1'b0 : oh_q;
    eff    = oh_q ? tgt_q >> 1 : tgt_q;
    diff   = (eff > spd_q) ? eff - spd_q : spd_q - eff;
    mv     = (diff > STEP_W) ? STEP_W : diff;
    spd_d  = cmd_stop ? '0 : !tick ? spd_q : (eff > spd_q) ? spd_q + mv : spd_q - mv;
    eff_d  = oh_d ? tgt_d >> 1 : tgt_d;
    // state tracks the registers it describes, so derive it from their next values
    st_d   = (spd_d == eff_d) ? ((eff_d == '0) ? IDLE : oh_d ? DERATE : HOLD)
                              : (oh_d ? DERATE : RAMP);
    duty_d = wrap ? spd_q : duty_q;
    pwm_d  = en & (cnt < duty_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q  <= '0;
      spd_q  <= '0;
      duty_q <= '0;
      oh_q   <= 1'b0;
      pwm_q  <= 1'b0;
      st_q   <= IDLE;
    end else begin
      tgt_q  <= tgt_d;
      spd_q  <= spd_d;
      duty_q <= duty_d;
      oh_q   <= oh_d;
      pwm_q  <= pwm_d;
      st_q   <= st_d;
    end
  end
  assign pwm      = pwm_q;
  assign speed    = spd_q;
  assign overheat = oh_q;
  assign busy     = (st_q == RAMP);
endmodule

// File: rtl/ev_motor_multi_ramp_pwm.sv
// ev_motor_multi_ramp_pwm: multi-channel ramped, derated PWM motor drive with a valid/ready command port.
module ev_motor_multi_ramp_pwm
  import ev_motor_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DW       = DEF_DW,
  parameter int IW       = DEF_IW,
  parameter int TW       = DEF_TW,
  parameter int RAMP_DIV = 16,
  parameter int STEP     = 4,
  parameter int T_HOT    = 85,
  parameter int T_COOL   = 75,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CW-1:0]     cmd_ch,
  input  logic [IW-1:0]     cmd_accel,
  input  logic [IW-1:0]     cmd_brake,
  input  logic              cmd_stop,
  input  logic [NCH*TW-1:0] temp_in,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH*DW-1:0] speed_out,
  output logic [NCH-1:0]    overheat,
  output logic              busy
);
  localparam int DVW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'((1 << DW) - 2);
  logic [DVW-1:0] div_q, div_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic tick, wrap, acc;
  logic [NCH-1:0] ch_busy;
  assign cmd_ready = en & ~rst;
  assign acc       = cmd_valid & cmd_ready;
  assign tick      = en & (div_q == DVW'(RAMP_DIV - 1));
  assign wrap      = en & (cnt_q == CNT_LAST);
  always_comb begin
    div_d = !en ? div_q : tick ? '0 : div_q + 1'b1;
    cnt_d = !en ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
  // out-of-range channel numbers match no instance, so those commands vanish
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ev_motor_channel #(
      .DW(DW), .IW(IW), .TW(TW), .STEP(STEP), .T_HOT(T_HOT), .T_COOL(T_COOL)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en),
      .tick(tick),
      .wrap(wrap),
      .cnt(cnt_q),
      .cmd_we(acc & ~cmd_stop & (cmd_ch == CW'(i))),
      .cmd_stop(acc & cmd_stop & (cmd_ch == CW'(i))),
      .accel(cmd_accel),
      .brake(cmd_brake),
      .temp(temp_in[i*TW +: TW]),
      .pwm(pwm_out[i]),
      .speed(speed_out[i*DW +: DW]),
      .overheat(overheat[i]),
      .busy(ch_busy[i])
    );
  end
  assign busy = |ch_busy;
endmodule

// File: tb/tb_ev_motor_multi_ramp_pwm.sv
// tb_ev_motor_multi_ramp_pwm: directed table, PWM period and reset sequences, then random traffic vs a cycle model.
module tb_ev_motor_multi_ramp_pwm;
  localparam int NCH = 3, DW = 8, IW = 4, TW = 7, RD = 16, STEP = 4, PER = 255;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, cmd_valid = 1'b0, cmd_stop = 1'b0;
  logic cmd_ready, busy;
  logic [1:0] cmd_ch = '0;
  logic [IW-1:0] cmd_accel = '0, cmd_brake = '0;
  logic [NCH*TW-1:0] temp_in;
  logic [NCH-1:0] pwm_out, overheat;
  logic [NCH*DW-1:0] speed_out;
  int checks = 0, errors = 0;
  int m_tgt[NCH], m_spd[NCH], m_duty[NCH], m_n;
  bit m_pwm[NCH], m_oh[NCH];
  int temps[NCH];

  ev_motor_multi_ramp_pwm #(.NCH(NCH), .DW(DW), .IW(IW), .TW(TW), .RAMP_DIV(RD), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_accel(cmd_accel), .cmd_brake(cmd_brake), .cmd_stop(cmd_stop),
    .temp_in(temp_in), .pwm_out(pwm_out), .speed_out(speed_out), .overheat(overheat), .busy(busy));

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < NCH; i++) temp_in[i*TW +: TW] = TW'(temps[i]);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_n = 0;
    for (int i = 0; i < NCH; i++) begin
      m_tgt[i] = 0; m_spd[i] = 0; m_duty[i] = 0; m_pwm[i] = 0; m_oh[i] = 0;
    end
  endfunction

  function automatic int eff_of(input int i);
    return m_oh[i] ? m_tgt[i] / 2 : m_tgt[i];
  endfunction

  // one clock of the behavioural model, using the inputs present at the edge
  function automatic void model_step();
    bit acc, tk, wr, hit;
    int cnt, d;
    if (rst) begin
      model_reset();
      return;
    end
    acc = cmd_valid && en;
    tk  = en && (m_n % RD == RD - 1);
    wr  = en && (m_n % PER == PER - 1);
    cnt = m_n % PER;
    for (int i = 0; i < NCH; i++) begin
      hit = acc && (int'(cmd_ch) == i);
      m_pwm[i] = en && (cnt < m_duty[i]);
      if (wr) m_duty[i] = m_spd[i];
      d = eff_of(i) - m_spd[i];
      d = (d > STEP) ? STEP : (d < -STEP) ? -STEP : d;
      if (hit && cmd_stop) m_spd[i] = 0;
      else if (tk) m_spd[i] += d;
      if (hit) m_tgt[i] = cmd_stop ? 0 : (cmd_accel > cmd_brake) ? (int'(cmd_accel) - int'(cmd_brake)) * 16 : 0;
      m_oh[i] = (temps[i] >= 85) ? 1'b1 : (temps[i] <= 75) ? 1'b0 : m_oh[i];
    end
    if (en) m_n++;
  endfunction

  function automatic int exp_busy();
    for (int i = 0; i < NCH; i++)
      if (!m_oh[i] && m_spd[i] != eff_of(i)) return 1;
    return 0;
  endfunction

  task automatic check_all();
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("speed%0d", i), int'(speed_out[i*DW +: DW]), m_spd[i]);
      chk($sformatf("overheat%0d", i), int'(overheat[i]), int'(m_oh[i]));
      chk($sformatf("pwm%0d", i), int'(pwm_out[i]), int'(m_pwm[i]));
    end
    chk("busy", int'(busy), exp_busy());
    chk("cmd_ready", int'(cmd_ready), int'(en & ~rst));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic period_highs(input int ch, input int exp);
    int highs = 0, budget = 0;
    do begin
      cycle();
      budget++;
    end while (m_n % PER != 0 && budget < 2 * PER);
    chk("period_align", int'(m_n % PER == 0), 1);
    for (int k = 0; k < PER; k++) begin
      cycle();
      highs += int'(pwm_out[ch]);
    end
    chk($sformatf("period_highs%0d", ch), highs, exp);
  endtask

  typedef struct {
    int ch; int accel; int brake; bit stop; int t0; int cyc;
    int exp_s0; int exp_s1; int exp_oh0; int exp_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic apply(input vec_t v, input int idx);
    temps[0] = v.t0;
    if (v.ch >= 0) begin
      cmd_valid = 1'b1;
      cmd_ch    = 2'(v.ch);
      cmd_accel = IW'(v.accel);
      cmd_brake = IW'(v.brake);
      cmd_stop  = v.stop;
    end
    cycle();
    cmd_valid = 1'b0;
    cmd_stop  = 1'b0;
    repeat (v.cyc - 1) cycle();
    chk($sformatf("vec%0d_speed0", idx), int'(speed_out[0 +: DW]), v.exp_s0);
    if (v.exp_s1 >= 0) chk($sformatf("vec%0d_speed1", idx), int'(speed_out[DW +: DW]), v.exp_s1);
    chk($sformatf("vec%0d_overheat0", idx), int'(overheat[0]), v.exp_oh0);
    chk($sformatf("vec%0d_busy", idx), int'(busy), v.exp_busy);
  endtask

  initial begin
    vecs[0] = '{0, 9, 1, 0, 25, 600, 128, 0, 0, 0};
    vecs[1] = '{-1, 0, 0, 0, 85, 300, 64, 0, 1, 0};
    vecs[2] = '{-1, 0, 0, 0, 80, 600, 64, 0, 1, 0};
    vecs[3] = '{-1, 0, 0, 0, 75, 600, 128, 0, 0, 0};
    vecs[4] = '{1, 15, 0, 0, 75, 100, 128, -1, 0, 1};
    vecs[5] = '{1, 0, 0, 1, 75, 1, 128, 0, 0, 0};
    vecs[6] = '{0, 3, 5, 0, 75, 600, 0, 0, 0, 0};
    vecs[7] = '{3, 9, 1, 0, 75, 600, 0, 0, 0, 0};
    for (int i = 0; i < NCH; i++) temps[i] = 25;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i], i);
      if (i == 2) period_highs(0, 64);
      if (i == 3) period_highs(0, 128);
    end
    // asynchronous reset mid-period with a hot, moving channel
    temps[0] = 90;
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_accel = 4'd9; cmd_brake = 4'd1;
    cycle();
    cmd_valid = 1'b0;
    repeat (150) cycle();
    chk("pre_reset_overheat0", int'(overheat[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_speed", int'(speed_out), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_overheat", int'(overheat), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      en        = ($urandom_range(0, 9) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_ch    = 2'($urandom_range(0, 3));
      cmd_accel = IW'($urandom_range(0, 15));
      cmd_brake = IW'($urandom_range(0, 15));
      cmd_stop  = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NCH; i++) begin
        temps[i] += $urandom_range(0, 4) - 2;
        temps[i] = (temps[i] < 60) ? 60 : (temps[i] > 100) ? 100 : temps[i];
        if ($urandom_range(0, 199) == 0) temps[i] = $urandom_range(60, 100);
      end
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
